// File: rtl/uart_rx.sv
`default_nettype none
// ============================================================================
// uart_rx : 8N1 asynchronous serial receiver, mid-bit sampling, fixed baud
// Revision : 1.0
// ============================================================================
module uart_rx #(
    parameter logic [31:0] CLK_FREQ = 32'd25_000_000,
    parameter logic [31:0] UART_BPS = 32'd921600
) (
    input  logic       sys_clk,
    input  logic       sys_rst_n,
    input  logic       rx,
    output logic [7:0] out_data,
    output logic       rx_done,
    output logic       frame_err,
    output logic       busy
);
    localparam logic [31:0] BPS_CNT = CLK_FREQ / UART_BPS;
    localparam logic [31:0] HALF    = BPS_CNT >> 1;
    localparam int          CNT_W   = (BPS_CNT > 32'd2) ? $clog2(BPS_CNT) : 1;
    localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(BPS_CNT - 32'd1);
    localparam logic [CNT_W-1:0] CNT_HALF = CNT_W'(HALF);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2,
        STOP  = 2'd3
    } state_t;

    state_t           state_q,    state_d;
    logic [CNT_W-1:0] baud_cnt_q, baud_cnt_d;
    logic [2:0]       bit_idx_q,  bit_idx_d;
    logic [7:0]       shift_q,    shift_d;
    logic [7:0]       out_data_q, out_data_d;
    logic             rx_done_q,  rx_done_d;
    logic             frame_err_q, frame_err_d;
    logic             rx_s1_q, rx_s2_q, rx_s3_q;

    logic             fall_edge;
    logic             sample_pt;

    assign fall_edge = rx_s3_q & ~rx_s2_q;
    assign sample_pt = (baud_cnt_q == CNT_HALF);

    // Synchronizer resets to the idle level so reset release never fakes a start edge
    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            rx_s1_q <= 1'b1;
            rx_s2_q <= 1'b1;
            rx_s3_q <= 1'b1;
        end else begin
            rx_s1_q <= rx;
            rx_s2_q <= rx_s1_q;
            rx_s3_q <= rx_s2_q;
        end
    end

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            state_q     <= IDLE;
            baud_cnt_q  <= '0;
            bit_idx_q   <= 3'd0;
            shift_q     <= 8'h00;
            out_data_q  <= 8'h00;
            rx_done_q   <= 1'b0;
            frame_err_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            baud_cnt_q  <= baud_cnt_d;
            bit_idx_q   <= bit_idx_d;
            shift_q     <= shift_d;
            out_data_q  <= out_data_d;
            rx_done_q   <= rx_done_d;
            frame_err_q <= frame_err_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        bit_idx_d   = bit_idx_q;
        shift_d     = shift_q;
        out_data_d  = out_data_q;
        rx_done_d   = 1'b0;
        frame_err_d = 1'b0;

        if (baud_cnt_q == CNT_MAX) begin
            baud_cnt_d = '0;
        end else begin
            baud_cnt_d = baud_cnt_q + CNT_W'(1);
        end

        case (state_q)
            IDLE: begin
                if (fall_edge) begin
                    state_d = START;
                end
            end
            START: begin
                if (sample_pt) begin
                    if (!rx_s2_q) begin
                        state_d   = DATA;
                        bit_idx_d = 3'd0;
                    end else begin
                        state_d = IDLE;
                    end
                end
            end
            DATA: begin
                if (sample_pt) begin
                    shift_d[bit_idx_q] = rx_s2_q;
                    if (bit_idx_q == 3'd7) begin
                        state_d = STOP;
                    end else begin
                        bit_idx_d = bit_idx_q + 3'd1;
                    end
                end
            end
            STOP: begin
                // Leaving at mid-stop leaves half a bit to catch a back-to-back start edge
                if (sample_pt) begin
                    if (rx_s2_q) begin
                        out_data_d = shift_q;
                        rx_done_d  = 1'b1;
                    end else begin
                        frame_err_d = 1'b1;
                    end
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        if (state_q == IDLE || state_d == IDLE) begin
            baud_cnt_d = '0;
        end
    end

    assign out_data  = out_data_q;
    assign rx_done   = rx_done_q;
    assign frame_err = frame_err_q;
    assign busy      = (state_q != IDLE);

endmodule
`default_nettype wire

// File: tb/tb_uart_rx.sv
`default_nettype none
// Self-checking bench for uart_rx: a frame-level decoder model of the line
// predicts strobes, data and busy on every cycle.
module tb_uart_rx;
    localparam int B    = 27;
    localparam int H    = 13;
    localparam int HMAX = 65536;

    logic       sys_clk   = 1'b0;
    logic       sys_rst_n = 1'b0;
    logic       rx        = 1'b1;
    logic [7:0] out_data;
    logic       rx_done;
    logic       frame_err;
    logic       busy;

    uart_rx #(
        .CLK_FREQ (32'd25_000_000),
        .UART_BPS (32'd921600)
    ) dut (
        .sys_clk   (sys_clk),
        .sys_rst_n (sys_rst_n),
        .rx        (rx),
        .out_data  (out_data),
        .rx_done   (rx_done),
        .frame_err (frame_err),
        .busy      (busy)
    );

    always #5 sys_clk = ~sys_clk;

    int cyc = 0;
    always @(posedge sys_clk) cyc <= cyc + 1;

    int tests = 0;
    int fails = 0;

    // Effective pin level per cycle (forced idle while reset holds the synchronizer)
    logic pin_hist [0:HMAX-1];

    // Model state
    bit         m_act   = 1'b0;
    bit         m_phase = 1'b0;
    int         m_e     = 0;
    int         m_chk   = 0;
    logic [7:0] m_data  = 8'h00;
    int         m_last_done = -1;
    int         m_done_cnt  = 0;

    // Observed DUT events
    int         done_cnt = 0;
    int         ferr_cnt = 0;
    int         last_done_cyc = -1;
    logic [7:0] last_done_data = 8'h00;
    logic [7:0] ferr_data = 8'h00;
    logic [7:0] done_q [$];
    int         busy_rise_cyc = -1;
    int         busy_fall_cyc = -1;
    logic       prev_busy = 1'b0;

    logic [7:0] exp3 [3] = '{8'h00, 8'hFF, 8'h5A};

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s at cycle %0d: got %0h, expected %0h", name, cyc, act, exp);
        end
    endtask

    function automatic logic pin_at(input int k);
        if (k < 0 || k >= HMAX) return 1'b1;
        return pin_hist[k];
    endfunction

    // Synchronized line as seen by the receiver: two cycles behind the pin
    function automatic logic d_at(input int k);
        return pin_at(k - 2);
    endfunction

    always @(negedge sys_clk) begin : cmp
        int         n;
        logic       e_done;
        logic       e_ferr;
        logic       e_busy;
        logic [7:0] byte_v;
        n      = cyc;
        byte_v = 8'h00;
        if (n < HMAX) pin_hist[n] = sys_rst_n ? rx : 1'b1;
        e_done = 1'b0;
        e_ferr = 1'b0;
        if (!sys_rst_n) begin
            m_act  = 1'b0;
            m_data = 8'h00;
        end else if (m_act && n == m_chk) begin
            if (!m_phase) begin
                if (d_at(m_e + 1 + H)) begin
                    m_act = 1'b0;
                end else begin
                    m_phase = 1'b1;
                    m_chk   = m_e + 2 + 9 * B + H;
                end
            end else begin
                for (int i = 0; i < 8; i++) byte_v[i] = d_at(m_e + 1 + B * (i + 1) + H);
                m_act = 1'b0;
                if (d_at(m_e + 1 + 9 * B + H)) begin
                    e_done      = 1'b1;
                    m_data      = byte_v;
                    m_last_done = n;
                    m_done_cnt++;
                end else begin
                    e_ferr = 1'b1;
                end
            end
        end
        e_busy = m_act;
        if (sys_rst_n && !m_act && d_at(n - 1) && !d_at(n)) begin
            m_act   = 1'b1;
            m_phase = 1'b0;
            m_e     = n;
            m_chk   = n + 2 + H;
        end

        chk("rx_done",   {31'd0, rx_done},   {31'd0, e_done});
        chk("frame_err", {31'd0, frame_err}, {31'd0, e_ferr});
        chk("busy",      {31'd0, busy},      {31'd0, e_busy});
        chk("out_data",  {24'd0, out_data},  {24'd0, m_data});

        if (rx_done === 1'b1) begin
            done_cnt++;
            last_done_cyc  = n;
            last_done_data = out_data;
            done_q.push_back(out_data);
        end
        if (frame_err === 1'b1) begin
            ferr_cnt++;
            ferr_data = out_data;
        end
        if (busy === 1'b1 && !prev_busy) busy_rise_cyc = n;
        if (busy === 1'b0 && prev_busy)  busy_fall_cyc = n;
        prev_busy = (busy === 1'b1);
    end

    task automatic drive(input logic v, input int k);
        repeat (k) begin
            @(posedge sys_clk);
            #1 rx = v;
        end
    endtask

    task automatic send(input logic [7:0] b, input int bpc, input logic stop, output int p0);
        @(posedge sys_clk);
        #1 rx = 1'b0;
        p0 = cyc;
        drive(1'b0, bpc - 1);
        for (int i = 0; i < 8; i++) drive(b[i], bpc);
        drive(stop, bpc);
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_out_data"},  {24'd0, out_data}, 32'h0);
        chk({tag, "_busy"},      {31'd0, busy},     32'h0);
        chk({tag, "_rx_done"},   {31'd0, rx_done},  32'h0);
        chk({tag, "_frame_err"}, {31'd0, frame_err}, 32'h0);
    endtask

    initial begin : watchdog
        #5_000_000;
        fails++;
        $display("FAIL watchdog: time limit reached at cycle %0d", cyc);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $fatal(1);
    end

    initial begin : main
        int p;
        int d0;
        int f0;
        int qs;
        logic [7:0] rb;
        int         rbpc;
        logic       rstop;
        for (int i = 0; i < HMAX; i++) pin_hist[i] = 1'b1;

        sys_rst_n = 1'b0;
        rx        = 1'b1;
        repeat (5) @(posedge sys_clk);
        #1;
        chk_reset_outputs("reset");
        sys_rst_n = 1'b1;
        drive(1'b1, 10);

        // Single nominal frame with absolute timing checks
        d0 = done_cnt; f0 = ferr_cnt;
        send(8'hA5, B, 1'b1, p);
        drive(1'b1, 30);
        chk("a5_done_cnt",      done_cnt - d0, 1);
        chk("a5_ferr_cnt",      ferr_cnt - f0, 0);
        chk("a5_data",          {24'd0, last_done_data}, 32'hA5);
        chk("a5_done_cycle",    last_done_cyc, p + 260);
        chk("a5_model_cycle",   m_last_done,   p + 260);
        chk("a5_busy_rise",     busy_rise_cyc, p + 3);
        chk("a5_busy_fall",     busy_fall_cyc, p + 260);

        // Back-to-back frames
        d0 = done_cnt; f0 = ferr_cnt; qs = done_q.size();
        send(8'h00, B, 1'b1, p);
        send(8'hFF, B, 1'b1, p);
        send(8'h5A, B, 1'b1, p);
        drive(1'b1, 30);
        chk("b2b_done_cnt", done_cnt - d0, 3);
        chk("b2b_ferr_cnt", ferr_cnt - f0, 0);
        for (int k = 0; k < 3; k++)
            chk("b2b_data", (done_q.size() > qs + k) ? {24'd0, done_q[qs + k]} : 32'hFFFF_FFFF,
                {24'd0, exp3[k]});

        // Short low glitch
        d0 = done_cnt; f0 = ferr_cnt;
        @(posedge sys_clk);
        #1 rx = 1'b0;
        p = cyc;
        drive(1'b0, 4);
        drive(1'b1, 60);
        chk("glitch_done_cnt", done_cnt - d0, 0);
        chk("glitch_ferr_cnt", ferr_cnt - f0, 0);
        chk("glitch_busy_fall", busy_fall_cyc, p + 17);
        chk("glitch_out_data", {24'd0, out_data}, 32'h5A);

        // Framing error, line held low, then recovery
        d0 = done_cnt; f0 = ferr_cnt;
        send(8'h3C, B, 1'b0, p);
        drive(1'b0, 40);
        drive(1'b1, 2 * B);
        chk("ferr_cnt",      ferr_cnt - f0, 1);
        chk("ferr_no_done",  done_cnt - d0, 0);
        chk("ferr_out_data", {24'd0, ferr_data}, 32'h5A);
        send(8'hC3, B, 1'b1, p);
        drive(1'b1, 30);
        chk("recover_done_cnt", done_cnt - d0, 1);
        chk("recover_data",     {24'd0, last_done_data}, 32'hC3);
        chk("recover_ferr_cnt", ferr_cnt - f0, 1);

        // Baud skew
        d0 = done_cnt; f0 = ferr_cnt;
        send(8'h96, 26, 1'b1, p);
        drive(1'b1, 30);
        chk("skew26_done_cnt", done_cnt - d0, 1);
        chk("skew26_data",     {24'd0, last_done_data}, 32'h96);
        send(8'h96, 28, 1'b1, p);
        drive(1'b1, 30);
        chk("skew28_done_cnt", done_cnt - d0, 2);
        chk("skew28_data",     {24'd0, last_done_data}, 32'h96);
        chk("skew_ferr_cnt",   ferr_cnt - f0, 0);

        // Reset during data bit 4 of 0xF0
        d0 = done_cnt; f0 = ferr_cnt;
        drive(1'b0, 5 * B);
        drive(1'b1, 10);
        sys_rst_n = 1'b0;
        drive(1'b1, 2);
        chk_reset_outputs("midrst");
        drive(1'b1, 3);
        sys_rst_n = 1'b1;
        drive(1'b1, (B - 15) + 4 * B);
        drive(1'b1, 10);
        chk("midrst_done_cnt", done_cnt - d0, 0);
        chk("midrst_ferr_cnt", ferr_cnt - f0, 0);
        send(8'h81, B, 1'b1, p);
        drive(1'b1, 30);
        chk("after_rst_done_cnt", done_cnt - d0, 1);
        chk("after_rst_data",     {24'd0, last_done_data}, 32'h81);

        // Randomized traffic: skewed baud, bad stop bits, glitches, variable gaps
        for (int t = 0; t < 25; t++) begin
            rb    = 8'($urandom);
            rbpc  = int'($urandom_range(26, 28));
            rstop = ($urandom_range(0, 7) != 0);
            send(rb, rbpc, rstop, p);
            if (!rstop) drive(1'b0, int'($urandom_range(0, 40)));
            if ($urandom_range(0, 5) == 0) begin
                drive(1'b1, int'($urandom_range(1, 30)));
                drive(1'b0, int'($urandom_range(1, 8)));
            end
            drive(1'b1, int'($urandom_range(0, 40)));
        end
        drive(1'b1, 2 * B);
        chk("rand_done_total", done_cnt, m_done_cnt);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
`default_nettype wire
